// File: rtl/stage_ex.sv
// -----------------------------------------------------------------------------
// stage_ex -- EX pipeline stage.
//
// Executes the ALU operation of the instruction issued by ID, detects signed
// overflow on ADDS/SUBS, and registers the result together with every control
// field into the EX/MEM pipeline register that feeds stage_MEM. Load/store
// addresses are produced here by the ALU (ADDU) and travel to MEM in ex_out.
//
// Ports
//   clk, reset        stage clock; asynchronous active-high reset
//   stall             hold the EX/MEM register (wins over flush)
//   flush, int_detect replace the next EX/MEM content with a bubble
//   fwd_data          unregistered ALU result for the forwarding network
//   id_*              instruction fields from ID
//   ex_*              registered EX/MEM fields towards stage_MEM
//
// A bubble is the same content as reset: everything zero, except the
// active-low GPR write enable, which is 1 (no write).
// -----------------------------------------------------------------------------
module stage_ex (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        int_detect,
    output logic [31:0] fwd_data,
    input  logic [29:0] id_pc,
    input  logic        id_en,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_in_0,
    input  logic [31:0] id_alu_in_1,
    input  logic        id_br_flag,
    input  logic [1:0]  id_mem_op,
    input  logic [31:0] id_mem_wr_data,
    input  logic [1:0]  id_ctrl_op,
    input  logic [5:0]  id_dst_addr,
    input  logic        id_gpr_we_,
    input  logic [2:0]  id_exp_code,
    output logic [29:0] ex_pc,
    output logic        ex_en,
    output logic        ex_br_flag,
    output logic [1:0]  ex_mem_op,
    output logic [31:0] ex_mem_wr_data,
    output logic [1:0]  ex_ctrl_op,
    output logic [5:0]  ex_dst_addr,
    output logic        ex_gpr_we_,
    output logic [2:0]  ex_exp_code,
    output logic [31:0] ex_out
);

    // ALU opcodes
    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_AND  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_ADDS = 4'd4;
    localparam logic [3:0] ALU_ADDU = 4'd5;
    localparam logic [3:0] ALU_SUBS = 4'd6;
    localparam logic [3:0] ALU_SUBU = 4'd7;
    localparam logic [3:0] ALU_SHRL = 4'd8;
    localparam logic [3:0] ALU_SHLL = 4'd9;

    localparam logic [2:0] EXP_NONE     = 3'd0;
    localparam logic [2:0] EXP_OVERFLOW = 3'd3;

    // -------------------------------------------------------------------------
    // ALU
    // -------------------------------------------------------------------------
    logic [31:0] alu_out;
    logic        alu_ovf;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    assign alu_a = id_alu_in_0;
    assign alu_b = id_alu_in_1;

    always_comb begin
        alu_out = 32'd0;
        case (id_alu_op)
            ALU_NOP:  alu_out = 32'd0;
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_ADDS: alu_out = alu_a + alu_b;
            ALU_ADDU: alu_out = alu_a + alu_b;
            ALU_SUBS: alu_out = alu_a - alu_b;
            ALU_SUBU: alu_out = alu_a - alu_b;
            ALU_SHRL: alu_out = alu_a >> alu_b[4:0];
            ALU_SHLL: alu_out = alu_a << alu_b[4:0];
            default:  alu_out = 32'd0;
        endcase
    end

    // Signed overflow: operand signs permit it and the result sign flipped
    // away from operand a. Unsigned variants never flag.
    always_comb begin
        alu_ovf = 1'b0;
        case (id_alu_op)
            ALU_ADDS: alu_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            ALU_SUBS: alu_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            default:  alu_ovf = 1'b0;
        endcase
    end

    assign fwd_data = alu_out;

    // -------------------------------------------------------------------------
    // EX/MEM pipeline register
    // -------------------------------------------------------------------------
    logic [29:0] pc_q,       pc_d;
    logic        en_q,       en_d;
    logic        br_flag_q,  br_flag_d;
    logic [1:0]  mem_op_q,   mem_op_d;
    logic [31:0] mem_wr_q,   mem_wr_d;
    logic [1:0]  ctrl_op_q,  ctrl_op_d;
    logic [5:0]  dst_addr_q, dst_addr_d;
    logic        gpr_we_q,   gpr_we_d;
    logic [2:0]  exp_code_q, exp_code_d;
    logic [31:0] out_q,      out_d;

    logic take_bubble;
    logic take_exception;

    assign take_bubble    = flush | int_detect;
    // An invalid ID slot never raises overflow; its fields pass through as-is.
    assign take_exception = alu_ovf & id_en;

    always_comb begin
        // default: hold (covers stall)
        pc_d       = pc_q;
        en_d       = en_q;
        br_flag_d  = br_flag_q;
        mem_op_d   = mem_op_q;
        mem_wr_d   = mem_wr_q;
        ctrl_op_d  = ctrl_op_q;
        dst_addr_d = dst_addr_q;
        gpr_we_d   = gpr_we_q;
        exp_code_d = exp_code_q;
        out_d      = out_q;

        if (!stall) begin
            if (take_bubble) begin
                pc_d       = 30'd0;
                en_d       = 1'b0;
                br_flag_d  = 1'b0;
                mem_op_d   = 2'd0;
                mem_wr_d   = 32'd0;
                ctrl_op_d  = 2'd0;
                dst_addr_d = 6'd0;
                gpr_we_d   = 1'b1;
                exp_code_d = EXP_NONE;
                out_d      = 32'd0;
            end else if (take_exception) begin
                // Keep PC/valid/branch so the exception can be attributed;
                // kill every side effect. Overflow overrides any ID code.
                pc_d       = id_pc;
                en_d       = id_en;
                br_flag_d  = id_br_flag;
                mem_op_d   = 2'd0;
                mem_wr_d   = 32'd0;
                ctrl_op_d  = 2'd0;
                dst_addr_d = 6'd0;
                gpr_we_d   = 1'b1;
                exp_code_d = EXP_OVERFLOW;
                out_d      = 32'd0;
            end else begin
                pc_d       = id_pc;
                en_d       = id_en;
                br_flag_d  = id_br_flag;
                mem_op_d   = id_mem_op;
                mem_wr_d   = id_mem_wr_data;
                ctrl_op_d  = id_ctrl_op;
                dst_addr_d = id_dst_addr;
                gpr_we_d   = id_gpr_we_;
                exp_code_d = id_exp_code;
                out_d      = alu_out;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= 30'd0;
            en_q       <= 1'b0;
            br_flag_q  <= 1'b0;
            mem_op_q   <= 2'd0;
            mem_wr_q   <= 32'd0;
            ctrl_op_q  <= 2'd0;
            dst_addr_q <= 6'd0;
            gpr_we_q   <= 1'b1;
            exp_code_q <= EXP_NONE;
            out_q      <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            en_q       <= en_d;
            br_flag_q  <= br_flag_d;
            mem_op_q   <= mem_op_d;
            mem_wr_q   <= mem_wr_d;
            ctrl_op_q  <= ctrl_op_d;
            dst_addr_q <= dst_addr_d;
            gpr_we_q   <= gpr_we_d;
            exp_code_q <= exp_code_d;
            out_q      <= out_d;
        end
    end

    assign ex_pc          = pc_q;
    assign ex_en          = en_q;
    assign ex_br_flag     = br_flag_q;
    assign ex_mem_op      = mem_op_q;
    assign ex_mem_wr_data = mem_wr_q;
    assign ex_ctrl_op     = ctrl_op_q;
    assign ex_dst_addr    = dst_addr_q;
    assign ex_gpr_we_     = gpr_we_q;
    assign ex_exp_code    = exp_code_q;
    assign ex_out         = out_q;

endmodule
